// File: rtl/simple_boolean_eval.sv
// simple_boolean_eval: 4-input Boolean function evaluator backed by a 16-entry
// runtime-reloadable truth table. F is the combinational lookup; f_q/f_valid
// give a registered, valid-qualified copy; hit_cnt counts accepted vectors
// that evaluated to 1, saturating at its maximum value.
module simple_boolean_eval #(
  parameter logic [15:0] TRUTH_TABLE = 16'hA5A5,
  parameter int          CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  output logic             F,
  input  logic             in_valid,
  output logic             f_q,
  output logic             f_valid,
  input  logic             cfg_we,
  input  logic [15:0]      cfg_tt,
  output logic [15:0]      tt_rd,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [15:0]      tt_q;
  logic [15:0]      tt_d;
  logic             f_d;
  logic             f_valid_q;
  logic             f_valid_d;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] hit_cnt_d;
  logic [3:0]       idx_s;
  logic             f_s;

  // Table lookup: index is {A,B,C,D}; X on an input may propagate to F.
  always_comb begin
    idx_s = {A, B, C, D};
    f_s   = tt_q[idx_s];
  end

  // Next-state: the registered path and counter sample F from the table held
  // before this edge, so a same-cycle reload does not affect them.
  always_comb begin
    tt_d      = tt_q;
    f_d       = f_q;
    f_valid_d = in_valid;
    hit_cnt_d = hit_cnt_q;

    if (cfg_we) begin
      tt_d = cfg_tt;
    end else begin
      tt_d = tt_q;
    end

    if (in_valid) begin
      f_d = f_s;
      if (f_s && (hit_cnt_q != CNT_MAX)) begin
        hit_cnt_d = hit_cnt_q + CNT_ONE;
      end else begin
        hit_cnt_d = hit_cnt_q;
      end
    end else begin
      f_d       = f_q;
      hit_cnt_d = hit_cnt_q;
    end
  end

  // State registers; reset restores the default table and clears outputs,
  // taking priority over any reload or valid input in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q      <= TRUTH_TABLE;
      f_q       <= 1'b0;
      f_valid_q <= 1'b0;
      hit_cnt_q <= CNT_ZERO;
    end else begin
      tt_q      <= tt_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign F       = f_s;
  assign f_valid = f_valid_q;
  assign tt_rd   = tt_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_simple_boolean_eval.sv
// tb_simple_boolean_eval: directed-vector bench for simple_boolean_eval.
// A second instance with a 2-bit counter shares the stimulus to observe saturation.
`timescale 1ns/1ps
module tb_simple_boolean_eval;

  logic        clk;
  logic        rst;
  logic        A, B, C, D;
  logic        in_valid;
  logic        cfg_we;
  logic [15:0] cfg_tt;
  logic        F, f_q, f_valid;
  logic [15:0] tt_rd;
  logic [7:0]  hit_cnt;
  logic        F2, f_q2, f_valid2;
  logic [15:0] tt_rd2;
  logic [1:0]  hit_cnt2;

  int n_tests;
  int n_fail;
  int exp_hits;
  logic [3:0] v;
  logic exp_f;

  simple_boolean_eval #(.TRUTH_TABLE(16'hA5A5), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .F(F),
    .in_valid(in_valid), .f_q(f_q), .f_valid(f_valid),
    .cfg_we(cfg_we), .cfg_tt(cfg_tt), .tt_rd(tt_rd), .hit_cnt(hit_cnt)
  );

  simple_boolean_eval #(.TRUTH_TABLE(16'hA5A5), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .F(F2),
    .in_valid(in_valid), .f_q(f_q2), .f_valid(f_valid2),
    .cfg_we(cfg_we), .cfg_tt(cfg_tt), .tt_rd(tt_rd2), .hit_cnt(hit_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_abcd(input logic [3:0] x);
    {A, B, C, D} = x;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; cfg_tt = 16'h0000;
    set_abcd(4'd0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_tt", tt_rd, 32'hA5A5);
    chk("rst_fq", f_q, 32'd0);
    chk("rst_fvalid", f_valid, 32'd0);
    chk("rst_hit", hit_cnt, 32'd0);

    // 1: combinational sweep, F = XNOR(B,D)
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      set_abcd(v);
      #1;
      exp_f = ~(v[2] ^ v[0]);
      chk($sformatf("sweep_F_%0d", i), F, exp_f);
    end
    chk("idle_fvalid", f_valid, 32'd0);
    chk("idle_fq_hold", f_q, 32'd0);

    // 2: clocked sweep with in_valid
    exp_hits = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v = i[3:0];
      set_abcd(v);
      in_valid = 1'b1;
      exp_f = ~(v[2] ^ v[0]);
      if (exp_f) exp_hits++;
      tick();
      chk($sformatf("pipe_fq_%0d", i), f_q, exp_f);
      chk($sformatf("pipe_fvalid_%0d", i), f_valid, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    set_abcd(4'b0101);
    tick();
    chk("sweep_hits", hit_cnt, 32'd8);
    chk("sweep_hits_model", hit_cnt, exp_hits);
    chk("sweep_hits_sat", hit_cnt2, 32'd3);
    chk("drop_fvalid", f_valid, 32'd0);
    chk("hold_fq", f_q, 32'd1);

    // 3: reload table with AND4
    @(negedge clk);
    cfg_we = 1'b1; cfg_tt = 16'h8000;
    tick();
    cfg_we = 1'b0;
    chk("cfg_tt_rd", tt_rd, 32'h8000);
    set_abcd(4'b1111); #1;
    chk("and4_1111", F, 32'd1);
    set_abcd(4'b1110); #1;
    chk("and4_1110", F, 32'd0);
    set_abcd(4'b0000); #1;
    chk("and4_0000", F, 32'd0);
    chk("cfg_hit_same", hit_cnt, 32'd8);

    // 4: reload and accept in the same cycle uses the old table
    @(negedge clk);
    cfg_we = 1'b1; cfg_tt = 16'hA5A5;
    tick();
    @(negedge clk);
    cfg_we = 1'b1; cfg_tt = 16'h0000; in_valid = 1'b1;
    set_abcd(4'b0000);
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("same_fq_old", f_q, 32'd1);
    chk("same_hit_old", hit_cnt, 32'd9);
    chk("same_tt_new", tt_rd, 32'h0000);
    chk("same_F_new", F, 32'd0);

    // 6: reset wins over cfg_we and in_valid
    @(negedge clk);
    rst = 1'b1; cfg_we = 1'b1; cfg_tt = 16'h1234; in_valid = 1'b1;
    set_abcd(4'b0000);
    tick();
    rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    chk("rstw_tt", tt_rd, 32'hA5A5);
    chk("rstw_fq", f_q, 32'd0);
    chk("rstw_fvalid", f_valid, 32'd0);
    chk("rstw_hit", hit_cnt, 32'd0);
    chk("rstw_F", F, 32'd1);

    // 5: five hits, 2-bit counter saturates at 3 (8-bit one reads 5)
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_abcd(4'b0000); in_valid = 1'b1;
      tick();
    end
    @(negedge clk);
    set_abcd(4'b0001); in_valid = 1'b1;
    tick();
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("sat_hit2", hit_cnt2, 32'd3);
    chk("sat_hit8", hit_cnt, 32'd5);
    chk("miss_fq", f_q, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
